// File: rtl/transfer_link_scheduler.sv
// transfer_link_scheduler
// Shares one bit-serial link between two scanners. Each grant becomes a
// two-byte frame (header, payload) shifted out MSB first in fixed 8-cycle
// slots aligned to reset release. Empty slots carry IDLE_BYTE so the
// receiver's byte counter stays in step.
//
// Build option: define SCHED_FIXED_PRIO_EN for fixed priority (scanner 0 wins
// simultaneous requests); otherwise simultaneous requests are round-robin.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous, active-low reset
//   link_ready  downstream ready, looked at only on slot boundaries
//   req[1:0]    per-scanner request, held with data stable until ack
//   ascii[1:0]  per-scanner payload type (1 = HDR_ASCII, 0 = HDR_BIN)
//   data0/1     scanner payload bytes
//   ack[1:0]    one-cycle grant pulse, payload already latched
//   tx_bit      serial output, MSB first
//   slot_start  high during the first bit of every slot
//   busy        high while a header or payload byte is on the wire
//   owner       scanner owning the current or last frame
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | idle byte on the wire
// ST_HDR   | header byte on the wire, payload follows next slot
// ST_PAY   | payload byte on the wire, next frame may follow directly

module transfer_link_scheduler #(
    parameter logic [7:0] IDLE_BYTE = 8'd0,
    parameter logic [7:0] HDR_BIN   = 8'd7,
    parameter logic [7:0] HDR_ASCII = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_ready,
    input  logic [1:0] req,
    input  logic [1:0] ascii,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] ack,
    output logic       tx_bit,
    output logic       slot_start,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    state_t     state_q,   state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q,   shreg_d;
    logic [7:0] pay_reg_q, pay_reg_d;
    logic [1:0] ack_q,     ack_d;
    logic       owner_q,   owner_d;

    logic       boundary;
    logic       winner;

    assign boundary = (bit_cnt_q == 3'd7);

`ifdef SCHED_FIXED_PRIO_EN
    // Scanner 0 always wins a tie.
    always_comb begin
        winner = ~req[0];
    end
`else
    // Round-robin without a separate pointer: on a tie the scanner that did
    // not own the last frame wins. owner resets to 1, so scanner 0 is
    // favoured after reset.
    always_comb begin
        winner = (req == 2'b11) ? ~owner_q : req[1];
    end
`endif

    always_comb begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shreg_d   = {shreg_q[6:0], 1'b0};
        state_d   = state_q;
        pay_reg_d = pay_reg_q;
        ack_d     = 2'b00;
        owner_d   = owner_q;

        if (boundary) begin
            case (state_q)
                ST_HDR: begin
                    // Payload always follows its header, link_ready or not.
                    shreg_d = pay_reg_q;
                    state_d = ST_PAY;
                end
                default: begin
                    if (link_ready && (req != 2'b00)) begin
                        shreg_d   = ascii[winner] ? HDR_ASCII : HDR_BIN;
                        pay_reg_d = winner ? data1 : data0;
                        ack_d     = winner ? 2'b10 : 2'b01;
                        owner_d   = winner;
                        state_d   = ST_HDR;
                    end else begin
                        shreg_d = IDLE_BYTE;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= IDLE_BYTE;
            pay_reg_q <= 8'd0;
            ack_q     <= 2'b00;
            owner_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            pay_reg_q <= pay_reg_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
        end
    end

    assign tx_bit     = shreg_q[7];
    assign slot_start = (bit_cnt_q == 3'd0);
    assign busy       = (state_q != ST_IDLE);
    assign ack        = ack_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_transfer_link_scheduler.sv
// Testbench for transfer_link_scheduler. A slot-level reference model runs on
// each rising edge, pushes one expected record per slot (byte, ack, busy,
// owner) into a queue; a monitor on the falling edge reassembles the serial
// byte and compares it against the queue head.

module tb_transfer_link_scheduler;

    localparam logic [7:0] IDLE_BYTE = 8'd0;
    localparam logic [7:0] HDR_BIN   = 8'd7;
    localparam logic [7:0] HDR_ASCII = 8'd8;

    logic       clk;
    logic       rst;
    logic       link_ready;
    logic [1:0] req;
    logic [1:0] ascii;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] ack;
    logic       tx_bit;
    logic       slot_start;
    logic       busy;
    logic       owner;

    transfer_link_scheduler #(
        .IDLE_BYTE (IDLE_BYTE),
        .HDR_BIN   (HDR_BIN),
        .HDR_ASCII (HDR_ASCII)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .link_ready (link_ready),
        .req        (req),
        .ascii      (ascii),
        .data0      (data0),
        .data1      (data1),
        .ack        (ack),
        .tx_bit     (tx_bit),
        .slot_start (slot_start),
        .busy       (busy),
        .owner      (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic [1:0] ack;
        logic       busy;
        logic       owner;
    } slot_exp_t;

    slot_exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state (slot level)
    int         mcnt    = 0;
    bit         started = 0;
    bit         have_pay;
    logic [7:0] mpay;
    logic       mowner;
    logic       rr_next;
    logic       w;
    slot_exp_t  rec;

    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            mcnt     = 0;
            have_pay = 0;
            mowner   = 1'b1;
            rr_next  = 1'b0;
            started  = 1;
            rec.val = IDLE_BYTE; rec.ack = 2'b00; rec.busy = 1'b0; rec.owner = 1'b1;
            exp_q.push_back(rec);
        end else begin
            if (mcnt == 7) begin
                if (have_pay) begin
                    rec.val = mpay; rec.ack = 2'b00; rec.busy = 1'b1; rec.owner = mowner;
                    have_pay = 0;
                end else if (link_ready && req != 2'b00) begin
`ifdef SCHED_FIXED_PRIO_EN
                    w = req[0] ? 1'b0 : 1'b1;
`else
                    w = (req == 2'b11) ? rr_next : req[1];
                    rr_next = ~w;
`endif
                    mpay     = w ? data1 : data0;
                    have_pay = 1;
                    mowner   = w;
                    rec.val   = ascii[w] ? HDR_ASCII : HDR_BIN;
                    rec.ack   = w ? 2'b10 : 2'b01;
                    rec.busy  = 1'b1;
                    rec.owner = w;
                end else begin
                    rec.val = IDLE_BYTE; rec.ack = 2'b00; rec.busy = 1'b0; rec.owner = mowner;
                end
                exp_q.push_back(rec);
            end
            mcnt = (mcnt + 1) % 8;
        end
    end

    // Monitor
    logic [7:0] acc;
    logic [1:0] ack0;
    logic [1:0] ack_rest;
    slot_exp_t  got;

    always @(negedge clk) begin
        if (started) begin
            if (mcnt == 0) begin
                acc      = 8'd0;
                ack0     = ack;
                ack_rest = 2'b00;
                if (exp_q.size() > 0) begin
                    checks++;
                    if (busy !== exp_q[0].busy) begin
                        errors++;
                        $display("FAIL busy: got %b expected %b at %0t", busy, exp_q[0].busy, $time);
                    end
                    checks++;
                    if (owner !== exp_q[0].owner) begin
                        errors++;
                        $display("FAIL owner: got %b expected %b at %0t", owner, exp_q[0].owner, $time);
                    end
                end
            end else begin
                ack_rest = ack_rest | ack;
            end
            acc = {acc[6:0], tx_bit};
            checks++;
            if (slot_start !== (mcnt == 0)) begin
                errors++;
                $display("FAIL slot_start: got %b expected %b at %0t", slot_start, (mcnt == 0), $time);
            end
            if (mcnt == 7) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL slot_queue: no expected slot record at %0t", $time);
                end else begin
                    got = exp_q.pop_front();
                    checks++;
                    if (acc !== got.val) begin
                        errors++;
                        $display("FAIL slot_byte: got %h expected %h at %0t", acc, got.val, $time);
                    end
                    checks++;
                    if (ack0 !== got.ack) begin
                        errors++;
                        $display("FAIL ack_pulse: got %b expected %b at %0t", ack0, got.ack, $time);
                    end
                    checks++;
                    if (ack_rest !== 2'b00) begin
                        errors++;
                        $display("FAIL ack_extra: got %b expected 00 at %0t", ack_rest, $time);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ack(input int max_cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            cyc(1);
            if (ack != 2'b00) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout: got no ack within %0d cycles expected an ack", max_cycles);
        end
    endtask

    initial begin
        rst        = 1'b0;
        link_ready = 1'b1;
        req        = 2'b00;
        ascii      = 2'b00;
        data0      = 8'h00;
        data1      = 8'h00;
        cyc(3);
        rst = 1'b1;

        // Quiet link after reset
        cyc(32);

        // Single binary frame from scanner 0
        data0 = 8'hA5;
        req   = 2'b01;
        wait_ack(20);
        req = 2'b00;
        cyc(32);

        // Both scanners requesting continuously
        data0 = 8'h11;
        data1 = 8'h22;
        ascii = 2'b10;
        req   = 2'b11;
        cyc(96);
        req = 2'b00;
        cyc(24);

        // Link not ready for three boundaries, then released
        link_ready = 1'b0;
        req        = 2'b10;
        cyc(24);
        link_ready = 1'b1;
        wait_ack(20);
        req = 2'b00;
        cyc(24);

        // link_ready drops during a header slot
        req = 2'b01;
        wait_ack(20);
        req = 2'b00;
        cyc(3);
        link_ready = 1'b0;
        req        = 2'b11;
        cyc(32);
        link_ready = 1'b1;
        cyc(40);
        req = 2'b00;
        cyc(24);

        // Reset at bit 3 of a payload slot, request still pending
        data0 = 8'h5C;
        req   = 2'b01;
        wait_ack(20);
        cyc(11);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        wait_ack(20);
        req = 2'b00;
        cyc(24);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ascii = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) data0 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) data1 = 8'($urandom);
            link_ready = ($urandom_range(0, 5) != 0);
            cyc(1);
        end
        req        = 2'b00;
        link_ready = 1'b1;
        cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transfer_link_scheduler.md
# transfer_link_scheduler

Transmit-side scheduler for the serial link into the transfer center. It shares that single bit-serial link between two local scanners. It frames each granted byte as a header command byte (binary 7 or ASCII 8) followed by one payload byte, sent MSB first in fixed 8-cycle slots aligned to reset release. Empty slots carry an idle byte so the receiver's free-running byte counter stays aligned.

## Interface
- `IDLE_BYTE`, default 8'd0: byte sent in empty slots; must not be 1..8.
- `HDR_BIN`, default 8'd7: header for binary payload.
- `HDR_ASCII`, default 8'd8: header for ASCII payload.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `link_ready` in 1: downstream ready for transfer; sampled only at slot boundaries.
- `req` in 2: per-scanner request; hold high with data stable until `ack`.
- `ascii` in 2: per-scanner payload type; 1 selects HDR_ASCII, 0 selects HDR_BIN.
- `data0` in 8: scanner 0 payload.
- `data1` in 8: scanner 1 payload.
- `ack` out 2: one-cycle pulse; payload latched, requester may change data or drop req.
- `tx_bit` out 1: serial stream to transfer center, MSB first.
- `slot_start` out 1: high during the first bit of every byte slot.
- `busy` out 1: high while a frame (header or payload) is on the wire.
- `owner` out 1: index of the scanner owning the current or last frame.

## Operation
- 3-bit `bit_cnt` free-runs from reset release (0..7, wraps 7 to 0). Slot boundary = clock edge where `bit_cnt`==7.
- 8-bit shift register `shreg`. `tx_bit` = `shreg[7]`. Shifts left each edge, except at a boundary edge, where it loads the next byte.
- FSM states: IDLE, HDR, PAY. Transitions occur only at boundary edges.
  - IDLE or PAY:
    - If `link_ready` and `req` != 0: choose a winner and load its header (by `ascii[winner]`). Latch the winner's data into `pay_reg`, pulse `ack[winner]`, set `owner`, go to HDR.
    - Otherwise load IDLE_BYTE and go to IDLE.
  - HDR: load `pay_reg`, go to PAY. `link_ready` is ignored here; the payload is always sent once the header is out.
- Back-to-back frames are allowed: from PAY straight into a new HDR with no idle slot.
- Arbitration (default): round-robin. Priority pointer points away from the last granted scanner. On reset it favours scanner 0.
- `req` sampled low at a boundary = no request; requests are not queued. Dropping `req` before `ack` is legal and withdraws the request.
- `busy` = state is HDR or PAY.
- Reset values:
  - `bit_cnt`=0, state IDLE, `shreg`=IDLE_BYTE, `pay_reg`=0.
  - `tx_bit`=IDLE_BYTE[7], `ack`=0, `busy`=0, `owner`=1.
  - `slot_start`=1 (first slot begins immediately).
- Reset mid-frame abandons the frame; no second `ack`. The downstream receiver must be reset alongside.

## Timing
- `slot_start` = (`bit_cnt`==0), combinational from the register.
- Grant latency: `req` high in the cycle before a boundary edge → `ack` high the cycle after that edge. The header MSB is on `tx_bit` in that same cycle.
- Header occupies 8 cycles, then the payload 8 cycles. A frame is 16 cycles.
- Worst-case wait for a single requester with `link_ready` high: 8 cycles to the next boundary.
- Worst case with contention: 8 + 16 cycles.
- Both `req` bits high at a boundary: exactly one `ack`. The loser is granted at the boundary after the winner's payload if still requesting.
- `link_ready` low at a boundary: idle slot sent, no `ack`, pointer unchanged.
- The `bit_cnt` wrap never stalls; `link_ready` cannot stretch a slot.

## Configuration
- `SCHED_FIXED_PRIO_EN` defined: fixed priority, scanner 0 always wins simultaneous requests, no pointer register.
- Not defined: round-robin as above.
- Everything else is identical.

## Test plan
- Reset release with `req`=0: `tx_bit` stays 0 for 32 cycles. `slot_start` pulses at cycles 0, 8, 16, 24. `busy`=0.
- `req`=2'b01, `ascii`=0, `data0`=8'hA5, `link_ready`=1: one `ack`=2'b01 pulse. Stream reads 8'h07 then 8'hA5 MSB first. Then idle slots.
- Both requesting continuously:
  - `data0`=8'h11, `data1`=8'h22, `ascii`=2'b10.
  - Frames alternate: 07/11, 08/22, 07/11 …, back-to-back.
  - Under `SCHED_FIXED_PRIO_EN`: only 07/11 repeats.
- `link_ready`=0 with `req`=2'b10 for 3 boundaries: idle bytes, no `ack`. Raise `link_ready`: grant at the next boundary.
- `link_ready` drops during a header slot: the payload byte is still sent intact. No new frame starts while it stays low.
- `rst` asserted at bit 3 of a payload slot: next cycle `tx_bit`=0, state IDLE, `bit_cnt`=0. A pending `req` is re-granted after release with a new `ack`.
